// File: rtl/downsampler_pkg.sv
// downsampler_pkg: shared widths, rounding constant and pixel/sum types for the downsampler
package downsampler_pkg;
    localparam int PIX_W  = 8;
    localparam int PAIR_W = 9;
    localparam int SUM_W  = 10;
    localparam logic [SUM_W-1:0] ROUND = SUM_W'(2);
    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [PAIR_W-1:0] pair_t;
    typedef logic [SUM_W-1:0]  sum_t;
endpackage

// File: rtl/downsampler_linebuf.sv
// downsampler_linebuf: simple dual-port RAM holding one half-width line of pair sums
module downsampler_linebuf
    import downsampler_pkg::*;
#(
    parameter int DEPTH = 320,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic          clock,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  pair_t         i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output pair_t         o_rd_data
);
    pair_t r_mem [DEPTH];
    pair_t r_rd_data;
    assign o_rd_data = r_rd_data;
    // write port
    always_ff @(posedge clock)
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    // registered read port; the word is held while idle so gaps in valid are harmless
    always_ff @(posedge clock)
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
endmodule

// File: rtl/downsampler.sv
// downsampler: 2x2 rounded box-average decimator for an 8-bit raster stream
module downsampler
    import downsampler_pkg::*;
#(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 9
)(
    input  logic             clock,
    input  logic             reset,
    input  logic [PIX_W-1:0] din,
    input  logic             valid,
    input  logic             sof,
    output logic [PIX_W-1:0] dataout,
    output logic             validout,
    output logic             eof
);
    localparam int AW = $clog2(WIDTH/2);
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(WIDTH-1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(HEIGHT-1);

    logic [COL_BITS-1:0] r_col, w_col;
    logic [ROW_BITS-1:0] r_row, w_row;
    pix_t  r_pair;
    pair_t w_pair_sum, w_lb_rd;
    sum_t  w_total;
    logic  w_emit, w_last;

    // sof overrides the counters so the current pixel is treated as (0,0)
    assign w_col      = (valid && sof) ? '0 : r_col;
    assign w_row      = (valid && sof) ? '0 : r_row;
    assign w_pair_sum = pair_t'(r_pair) + pair_t'(din);
    assign w_total    = sum_t'(w_lb_rd) + sum_t'(w_pair_sum) + ROUND;
    assign w_emit     = valid && w_row[0] && w_col[0];
    assign w_last     = (w_col == COL_LAST) && (w_row == ROW_LAST);

    downsampler_linebuf #(.DEPTH(WIDTH/2), .AW(AW)) u_linebuf (
        .clock     (clock),
        .i_wr_en   (valid && !w_row[0] && w_col[0]),
        .i_wr_addr (w_col[AW:1]),
        .i_wr_data (w_pair_sum),
        .i_rd_en   (valid && w_row[0] && !w_col[0]),
        .i_rd_addr (w_col[AW:1]),
        .o_rd_data (w_lb_rd)
    );

    // raster position counters and even-column pair register
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_pair <= '0;
        end else if (valid) begin
            r_col <= (w_col == COL_LAST) ? '0 : w_col + 1'b1;
            r_row <= (w_col != COL_LAST) ? w_row : (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            if (!w_col[0]) r_pair <= din;
        end

    // registered output stage; dataout holds its last value between outputs
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            dataout  <= '0;
            validout <= 1'b0;
            eof      <= 1'b0;
        end else begin
            validout <= w_emit;
            eof      <= w_emit && w_last;
            if (w_emit) dataout <= PIX_W'(w_total >> 2);
        end
endmodule
